idli_mshift_m: RTL and testbench
================================

Name: idli_mshift_m

Overview:
- Multi-position, slice-serial shift/rotate unit. Successor to the single-position slice shifter; supports any shift amount 0..W-1.
- Word width is parametrised as W = SLICE_W*NUM_SLICES. The operand arrives one slice per cycle, LSB slice first.
- The block buffers the whole word, then streams the shifted result back out slice-serially with a carry-out.
- Load and output buffers are separate, so back-to-back ops pipeline at one op per NUM_SLICES cycles.

Parameters:
- SLICE_W, 4, bits per serial slice.
- NUM_SLICES, 4, slices per word (>=2); W = SLICE_W*NUM_SLICES, AMT_W = $clog2(W).

Ports:
- i_msh_gck  in  1  clock.
- i_msh_rst  in  1  synchronous, active-high reset.
- i_msh_valid  in  1  input slice valid.
- i_msh_start  in  1  marks first (LSB) slice of an operand; only meaningful with valid.
- i_msh_op  in  3  op, sampled with start: 0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR, 5-7 reserved.
- i_msh_amt  in  AMT_W  shift amount, sampled with start.
- i_msh_in  in  SLICE_W  operand slice.
- o_msh_valid  out  1  output slice valid.
- o_msh_first  out  1  marks first (LSB) output slice.
- o_msh_out  out  SLICE_W  result slice.
- o_msh_cout  out  1  carry-out of current result.

Behaviour:
- Load FSM has two states, IDLE and LOAD, plus a load slice counter lctr (0..NUM_SLICES-1).
- IDLE:
  - valid&start: capture op/amt, write slice to load buffer slot 0, lctr=1, go to LOAD.
  - valid without start: ignored.
- LOAD:
  - valid&~start: write slot lctr, increment lctr.
  - ~valid: abort, go to IDLE. No output is produced and the output stage is unaffected.
  - valid&start: restart. Treat as a new first slice: recapture op/amt, lctr=1.
- Last-load cycle T (valid, lctr==NUM_SLICES-1):
  - Compute the result combinationally from buffered slices plus the current slice.
  - Register the result into the output buffer, along with cout.
  - Go to IDLE. A start is accepted from T+1.
- Result rules for amount n and operand x:
  - SLL: x<<n, zero fill.
  - SRL: x>>n, zero fill.
  - SRA: x>>n, fill with x[W-1].
  - ROL / ROR: rotate by n.
  - Reserved ops: result = x, cout = 0.
- Carry-out rules:
  - Right ops (SRL/SRA/ROR): cout = x[n-1].
  - Left ops (SLL/ROL): cout = x[W-n].
  - n==0: result = x, cout = 0.
- Output stage:
  - Output counter octr, valid flag.
  - Slices k=0..NUM_SLICES-1 driven on cycles T+1..T+NUM_SLICES.
  - o_msh_valid=1 on those cycles; o_msh_first=1 only at T+1; o_msh_out = result[k*SLICE_W +: SLICE_W].
- o_msh_cout updates at T+1 and holds until the next result's first output cycle.
- Pipelining:
  - A new op may start at T+1; its last load lands at T+NUM_SLICES.
  - Its output begins at T+NUM_SLICES+1, seamless with the prior op: valid stays high and first pulses again.
  - The output buffer is overwritten only on a last-load edge. The current final slice is read before that edge, so no conflict exists.
- Outside output cycles: o_msh_valid=0, o_msh_first=0, o_msh_out=0.
- Latency: first result slice one cycle after last input slice.
- Reset, including mid-load or mid-output:
  - Next cycle: load FSM IDLE, counters 0.
  - o_msh_valid=0, o_msh_first=0, o_msh_out=0, o_msh_cout=0.
  - Any in-flight op is discarded.
  - Reset overrides valid/start in the same cycle.

Test Plan:
1. SRL 0x8001 by 1 (slices 1,0,0,8) -> output slices 0,0,0,4 (0x4000) starting one cycle after last input, first on slice 0, cout=1.
2. SRA 0x8000 by 4 -> 0xF800, cout=0. SLL 0x0001 by 15 -> 0x8000, cout=0. SLL 0x8000 by 1 -> 0x0000, cout=1.
3. ROL 0x1234 by 4 -> 0x2341, cout=1. ROR 0x1234 by 4 -> 0x4123, cout=0. Any op with amt 0 -> 0x1234, cout=0. Reserved op 6 -> 0x1234, cout=0.
4. Back-to-back: ROR 0x0001 by 1 then SRL 0xFFFF by 8 with no gap.
   - Outputs 0x8000 (cout 1) then 0x00FF (cout 1).
   - o_msh_valid continuously high for 8 cycles, first pulses at output cycles 1 and 5.
5. Abort/restart:
   - Valid dropped after 2 slices -> no output.
   - Start reasserted at slice 3 -> only the restarted operand is produced, using the newly sampled op/amt.
6. Reset asserted mid-output (2nd slice) with a new op half-loaded:
   - Next cycle all outputs 0.
   - A subsequent fresh op completes correctly.

Source files
------------

// File: rtl/idli_mshift_m.sv
// Slice-serial multi-position shift/rotate unit: buffers one operand word, then
// streams the shifted result out LSB slice first, one slice per cycle.
module idli_mshift_m #(
    parameter  int unsigned SLICE_W    = 4,
    parameter  int unsigned NUM_SLICES = 4,
    localparam int unsigned W          = SLICE_W * NUM_SLICES,
    localparam int unsigned AMT_W      = $clog2(W)
) (
    input  logic               i_msh_gck,
    input  logic               i_msh_rst,
    input  logic               i_msh_valid,
    input  logic               i_msh_start,
    input  logic [2:0]         i_msh_op,
    input  logic [AMT_W-1:0]   i_msh_amt,
    input  logic [SLICE_W-1:0] i_msh_in,
    output logic               o_msh_valid,
    output logic               o_msh_first,
    output logic [SLICE_W-1:0] o_msh_out,
    output logic               o_msh_cout
);

    localparam int unsigned CTR_W  = $clog2(NUM_SLICES);
    localparam int unsigned LBUF_W = W - SLICE_W;
    localparam logic [CTR_W-1:0] LAST_SLICE = CTR_W'(NUM_SLICES - 1);

    localparam logic [2:0] OP_SLL = 3'd0;
    localparam logic [2:0] OP_SRL = 3'd1;
    localparam logic [2:0] OP_SRA = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOAD = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CTR_W-1:0]    lctr_q, lctr_d;
    logic [LBUF_W-1:0]   lbuf_q, lbuf_d;
    logic [2:0]          op_q, op_d;
    logic [AMT_W-1:0]    amt_q, amt_d;
    logic                last_c;

    logic [W-1:0]        obuf_q, obuf_d;
    logic [CTR_W-1:0]    octr_q, octr_d;
    logic                obusy_q, obusy_d;
    logic                ovalid_q, ovalid_d;
    logic                ofirst_q, ofirst_d;
    logic [SLICE_W-1:0]  oout_q, oout_d;
    logic                ocout_q, ocout_d;

    logic [W-1:0]        x_c;
    logic [2*W-1:0]      dbl_c;
    logic [2*W-1:0]      sext_c;
    logic [W-1:0]        res_c;
    logic                cout_c;
    logic [AMT_W-1:0]    ridx_c;
    logic [AMT_W-1:0]    lidx_c;

    // Load FSM: collect slices; a start always (re)captures op/amt as slice 0.
    always_comb begin
        state_d = state_q;
        lctr_d  = lctr_q;
        lbuf_d  = lbuf_q;
        op_d    = op_q;
        amt_d   = amt_q;
        last_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_msh_valid && i_msh_start) begin
                    op_d                 = i_msh_op;
                    amt_d                = i_msh_amt;
                    lbuf_d[SLICE_W-1:0]  = i_msh_in;
                    lctr_d               = CTR_W'(1);
                    state_d              = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!i_msh_valid) begin
                    lctr_d  = '0;
                    state_d = S_IDLE;
                end else if (i_msh_start) begin
                    op_d                 = i_msh_op;
                    amt_d                = i_msh_amt;
                    lbuf_d[SLICE_W-1:0]  = i_msh_in;
                    lctr_d               = CTR_W'(1);
                end else if (lctr_q == LAST_SLICE) begin
                    last_c  = 1'b1;
                    lctr_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    lbuf_d[lctr_q*SLICE_W +: SLICE_W] = i_msh_in;
                    lctr_d = lctr_q + CTR_W'(1);
                end
            end
            default: begin
                lctr_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Result datapath; the final slice bypasses the load buffer.
    always_comb begin
        x_c    = {i_msh_in, lbuf_q};
        dbl_c  = {x_c, x_c};
        sext_c = {{W{x_c[W-1]}}, x_c};
        ridx_c = amt_q - AMT_W'(1);
        lidx_c = AMT_W'(W - int'(amt_q));
        case (op_q)
            OP_SLL:  res_c = x_c << amt_q;
            OP_SRL:  res_c = x_c >> amt_q;
            OP_SRA:  res_c = W'(sext_c >> amt_q);
            OP_ROL:  res_c = W'((dbl_c << amt_q) >> W);
            OP_ROR:  res_c = W'(dbl_c >> amt_q);
            default: res_c = x_c;
        endcase
        cout_c = 1'b0;
        if (amt_q != '0) begin
            case (op_q)
                OP_SRL, OP_SRA, OP_ROR: cout_c = x_c[ridx_c];
                OP_SLL, OP_ROL:         cout_c = x_c[lidx_c];
                default:                cout_c = 1'b0;
            endcase
        end
    end

    // Output stage: a new result always wins; otherwise drain remaining slices.
    always_comb begin
        obuf_d   = obuf_q;
        octr_d   = octr_q;
        obusy_d  = obusy_q;
        ovalid_d = 1'b0;
        ofirst_d = 1'b0;
        oout_d   = '0;
        ocout_d  = ocout_q;
        if (last_c) begin
            obuf_d   = res_c;
            oout_d   = res_c[SLICE_W-1:0];
            ovalid_d = 1'b1;
            ofirst_d = 1'b1;
            ocout_d  = cout_c;
            octr_d   = CTR_W'(1);
            obusy_d  = 1'b1;
        end else if (obusy_q) begin
            oout_d   = obuf_q[octr_q*SLICE_W +: SLICE_W];
            ovalid_d = 1'b1;
            if (octr_q == LAST_SLICE) begin
                octr_d  = '0;
                obusy_d = 1'b0;
            end else begin
                octr_d  = octr_q + CTR_W'(1);
            end
        end
    end

    always_ff @(posedge i_msh_gck) begin
        if (i_msh_rst) begin
            state_q  <= S_IDLE;
            lctr_q   <= '0;
            lbuf_q   <= '0;
            op_q     <= '0;
            amt_q    <= '0;
            obuf_q   <= '0;
            octr_q   <= '0;
            obusy_q  <= 1'b0;
            ovalid_q <= 1'b0;
            ofirst_q <= 1'b0;
            oout_q   <= '0;
            ocout_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            lctr_q   <= lctr_d;
            lbuf_q   <= lbuf_d;
            op_q     <= op_d;
            amt_q    <= amt_d;
            obuf_q   <= obuf_d;
            octr_q   <= octr_d;
            obusy_q  <= obusy_d;
            ovalid_q <= ovalid_d;
            ofirst_q <= ofirst_d;
            oout_q   <= oout_d;
            ocout_q  <= ocout_d;
        end
    end

    assign o_msh_valid = ovalid_q;
    assign o_msh_first = ofirst_q;
    assign o_msh_out   = oout_q;
    assign o_msh_cout  = ocout_q;

endmodule

// File: tb/tb_idli_mshift_m.sv
// Directed bench for idli_mshift_m: vector table of single ops plus
// hand-written back-to-back, abort/restart and mid-output reset sequences.
module tb_idli_mshift_m;

    localparam logic [2:0] SLL = 3'd0;
    localparam logic [2:0] SRL = 3'd1;
    localparam logic [2:0] SRA = 3'd2;
    localparam logic [2:0] ROL = 3'd3;
    localparam logic [2:0] ROR = 3'd4;

    logic       clk;
    logic       rst;
    logic       i_valid;
    logic       i_start;
    logic [2:0] i_op;
    logic [3:0] i_amt;
    logic [3:0] i_in;
    logic       o_valid;
    logic       o_first;
    logic [3:0] o_out;
    logic       o_cout;

    int    checks;
    int    failures;
    string tag;
    logic  cur_cout;

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  amt;
        logic [15:0] x;
        logic [15:0] res;
        logic        cout;
    } vec_t;

    vec_t vecs[16];

    idli_mshift_m dut (
        .i_msh_gck   (clk),
        .i_msh_rst   (rst),
        .i_msh_valid (i_valid),
        .i_msh_start (i_start),
        .i_msh_op    (i_op),
        .i_msh_amt   (i_amt),
        .i_msh_in    (i_in),
        .o_msh_valid (o_valid),
        .o_msh_first (o_first),
        .o_msh_out   (o_out),
        .o_msh_cout  (o_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s %s: got %0h expected %0h", tag, nm, act, exp);
        end
    endtask

    // One clock: check outputs from the last edge, then drive inputs for the next.
    task automatic cyc(input logic r, input logic v, input logic s,
                       input logic [2:0] op, input logic [3:0] amt, input logic [3:0] din,
                       input logic ev, input logic ef, input logic [3:0] eo, input logic ec);
        @(posedge clk);
        #1;
        chk("valid", 32'(o_valid), 32'(ev));
        chk("first", 32'(o_first), 32'(ef));
        chk("out",   32'(o_out),   32'(eo));
        chk("cout",  32'(o_cout),  32'(ec));
        rst     = r;
        i_valid = v;
        i_start = s;
        i_op    = op;
        i_amt   = amt;
        i_in    = din;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [3:0] amt,
                          input logic [15:0] x, input logic [15:0] res, input logic ec);
        for (int k = 0; k < 4; k++)
            cyc(1'b0, 1'b1, k == 0, op, amt, x[k*4 +: 4], 1'b0, 1'b0, 4'h0, cur_cout);
        for (int j = 0; j < 4; j++)
            cyc(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'h0, 1'b1, j == 0, res[j*4 +: 4], ec);
        cur_cout = ec;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cur_cout = 1'b0;
        tag      = "reset";

        vecs[0]  = '{SRL,  4'd1,  16'h8001, 16'h4000, 1'b1};
        vecs[1]  = '{SRA,  4'd4,  16'h8000, 16'hF800, 1'b0};
        vecs[2]  = '{SLL,  4'd15, 16'h0001, 16'h8000, 1'b0};
        vecs[3]  = '{SLL,  4'd1,  16'h8000, 16'h0000, 1'b1};
        vecs[4]  = '{ROL,  4'd4,  16'h1234, 16'h2341, 1'b1};
        vecs[5]  = '{ROR,  4'd4,  16'h1234, 16'h4123, 1'b0};
        vecs[6]  = '{SLL,  4'd0,  16'h1234, 16'h1234, 1'b0};
        vecs[7]  = '{SRL,  4'd0,  16'h1234, 16'h1234, 1'b0};
        vecs[8]  = '{SRA,  4'd0,  16'h1234, 16'h1234, 1'b0};
        vecs[9]  = '{ROL,  4'd0,  16'h1234, 16'h1234, 1'b0};
        vecs[10] = '{ROR,  4'd0,  16'h1234, 16'h1234, 1'b0};
        vecs[11] = '{3'd6, 4'd5,  16'h1234, 16'h1234, 1'b0};
        vecs[12] = '{3'd7, 4'd3,  16'h1234, 16'h1234, 1'b0};
        vecs[13] = '{SRL,  4'd15, 16'hFFFF, 16'h0001, 1'b1};
        vecs[14] = '{ROR,  4'd15, 16'h8001, 16'h0003, 1'b0};
        vecs[15] = '{SRA,  4'd2,  16'h8006, 16'hE001, 1'b1};

        rst = 1'b1; i_valid = 1'b0; i_start = 1'b0; i_op = 3'd0; i_amt = 4'd0; i_in = 4'h0;
        repeat (2) @(posedge clk);
        cyc(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);

        // Ignored slice: valid without start in IDLE must not begin a load.
        tag = "nostart";
        for (int k = 0; k < 6; k++)
            cyc(1'b0, 1'b1, 1'b0, SRL, 4'd1, 4'hF, 1'b0, 1'b0, 4'h0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            tag = $sformatf("vec%0d", i);
            run_op(vecs[i].op, vecs[i].amt, vecs[i].x, vecs[i].res, vecs[i].cout);
        end

        // Back-to-back: ROR 0x0001>>1 then SRL 0xFFFF>>8 with no gap.
        tag = "b2b";
        for (int k = 0; k < 4; k++)
            cyc(1'b0, 1'b1, k == 0, ROR, 4'd1, (k == 0) ? 4'h1 : 4'h0, 1'b0, 1'b0, 4'h0, cur_cout);
        for (int k = 0; k < 4; k++)
            cyc(1'b0, 1'b1, k == 0, SRL, 4'd8, 4'hF, 1'b1, k == 0, (k == 3) ? 4'h8 : 4'h0, 1'b1);
        for (int k = 0; k < 4; k++)
            cyc(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'h0, 1'b1, k == 0, (k < 2) ? 4'hF : 4'h0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1);
        cur_cout = 1'b1;

        // Abort after two slices: no output at all.
        tag = "abort";
        cyc(1'b0, 1'b1, 1'b1, SLL, 4'd1, 4'h1, 1'b0, 1'b0, 4'h0, cur_cout);
        cyc(1'b0, 1'b1, 1'b0, SLL, 4'd1, 4'h2, 1'b0, 1'b0, 4'h0, cur_cout);
        for (int k = 0; k < 7; k++)
            cyc(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'h0, 1'b0, 1'b0, 4'h0, cur_cout);

        // Restart at the third slice with a new op/amt.
        tag = "restart";
        cyc(1'b0, 1'b1, 1'b1, SLL, 4'd8, 4'hA, 1'b0, 1'b0, 4'h0, cur_cout);
        cyc(1'b0, 1'b1, 1'b0, SLL, 4'd8, 4'hB, 1'b0, 1'b0, 4'h0, cur_cout);
        run_op(ROR, 4'd4, 16'h1234, 16'h4123, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);

        // Reset during the second output slice while a new op is half-loaded.
        tag = "midreset";
        cyc(1'b0, 1'b1, 1'b1, ROL, 4'd4, 4'h4, 1'b0, 1'b0, 4'h0, cur_cout);
        cyc(1'b0, 1'b1, 1'b0, ROL, 4'd4, 4'h3, 1'b0, 1'b0, 4'h0, cur_cout);
        cyc(1'b0, 1'b1, 1'b0, ROL, 4'd4, 4'h2, 1'b0, 1'b0, 4'h0, cur_cout);
        cyc(1'b0, 1'b1, 1'b0, ROL, 4'd4, 4'h1, 1'b0, 1'b0, 4'h0, cur_cout);
        cyc(1'b0, 1'b1, 1'b1, SRL, 4'd1, 4'h1, 1'b1, 1'b1, 4'h1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, SRL, 4'd1, 4'h0, 1'b1, 1'b0, 4'h4, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, SRL, 4'd1, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, SRL, 4'd1, 4'h8, 1'b0, 1'b0, 4'h0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
        cur_cout = 1'b0;
        tag = "postreset";
        run_op(SRL, 4'd1, 16'h8001, 16'h4000, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
